// File: rtl/nmea_rmc_parse.sv
// nmea_rmc_parse: byte-stream parser for NMEA-0183 RMC sentences (any talker ID).
// Extracts local time, fix status, lat/lon and integer speed; outputs update only
// when a complete, well-formed sentence ends with CR.
// Optional build macro: NMEA_CKSUM_EN enables checking of the two hex checksum digits.
module nmea_rmc_parse #(
  parameter int TZ_HR    = 0,
  parameter int FRAC_DIG = 4,
  parameter int SPD_W    = 10,
  parameter int MAX_LEN  = 82
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       char,
  input  logic             valid,
  output logic             NSR,
  output logic             err,
  output logic [4:0]       hr,
  output logic [5:0]       min,
  output logic [5:0]       sec,
  output logic             fix,
  output logic [6:0]       lat_deg,
  output logic [5:0]       lat_min,
  output logic [13:0]      lat_frac,
  output logic             lat_s,
  output logic [7:0]       lon_deg,
  output logic [5:0]       lon_min,
  output logic [13:0]      lon_frac,
  output logic             lon_w,
  output logic [SPD_W-1:0] spd_kn
);

  typedef enum logic [1:0] {IDLE, HDR, FLD, CKS} state_t;

  localparam logic [7:0] C_DOL = 8'h24;
  localparam logic [7:0] C_COM = 8'h2C;
  localparam logic [7:0] C_DOT = 8'h2E;
  localparam logic [7:0] C_AST = 8'h2A;
  localparam logic [7:0] C_CR  = 8'h0D;

  localparam logic [7:0]        MAXL    = 8'(MAX_LEN);
  localparam logic [2:0]        FRAC_N  = 3'(FRAC_DIG);
  localparam logic signed [7:0] TZ8     = 8'(TZ_HR);
  localparam logic [SPD_W+3:0]  SPD_MAX = {4'b0, {SPD_W{1'b1}}};
  localparam logic [SPD_W+3:0]  TEN_W   = (SPD_W+4)'(10);

  state_t state, state_n;

  // sentence-in-progress bookkeeping
  logic [7:0] len;
  logic [2:0] hdr_cnt;
  logic [3:0] fld;
  logic [3:0] pos;
  logic       in_frac;
  logic [2:0] fcnt;
  logic       bad;

  // shadow copies of the fields being parsed
  logic [6:0]       s_hr;
  logic [5:0]       s_min, s_sec, s_latm, s_lonm;
  logic             s_fix, s_lats, s_lonw;
  logic [6:0]       s_latd;
  logic [7:0]       s_lond;
  logic [13:0]      s_latf, s_lonf;
  logic [SPD_W-1:0] s_spd;

  // per-byte control decoded by the FSM
  logic restart, commit, fail, hdr_step, fld_step, cks_step, good;

  logic             is_dig, is_up, hdr_ok;
  logic [3:0]       dig;
  logic [2:0]       fidx;
  logic [13:0]      frac_add;
  logic [SPD_W+3:0] spd_wide;
  logic [SPD_W-1:0] spd_nx;
  logic signed [7:0] hsum;
  logic [4:0]       hr_loc;

`ifdef NMEA_CKSUM_EN
  logic [7:0] xr;
  logic [7:0] rx_ck;
  logic [1:0] hcnt;
  logic       hex_ok;
  logic [3:0] hex_v;
`endif

  function automatic logic [7:0] dec(input logic [7:0] a, input logic [3:0] d);
    return 8'(a * 8'd10) + {4'b0, d};
  endfunction

  function automatic logic [13:0] pw10(input logic [2:0] n);
    case (n)
      3'd0:    return 14'd1;
      3'd1:    return 14'd10;
      3'd2:    return 14'd100;
      default: return 14'd1000;
    endcase
  endfunction

  // character classification and per-field arithmetic helpers
  always_comb begin
    is_dig   = (char >= 8'h30) && (char <= 8'h39);
    is_up    = (char >= 8'h41) && (char <= 8'h5A);
    dig      = char[3:0];
    case (hdr_cnt)
      3'd0, 3'd1: hdr_ok = is_up;
      3'd2:       hdr_ok = (char == 8'h52);
      3'd3:       hdr_ok = (char == 8'h4D);
      default:    hdr_ok = (char == 8'h43);
    endcase
    fidx     = 3'(FRAC_DIG - 1) - fcnt;
    frac_add = 14'(dig) * pw10(fidx);
    spd_wide = ({4'b0, s_spd} * TEN_W) + {{SPD_W{1'b0}}, dig};
    spd_nx   = (spd_wide > SPD_MAX) ? '1 : spd_wide[SPD_W-1:0];
  end

  // local hour: widened signed sum so +14 on hour 23 cannot wrap before the mod-24 fold
  always_comb begin
    hsum = $signed({1'b0, s_hr}) + TZ8;
    if (hsum < 8'sd0)       hr_loc = 5'(hsum + 8'sd24);
    else if (hsum >= 8'sd24) hr_loc = 5'(hsum - 8'sd24);
    else                     hr_loc = 5'(hsum);
  end

`ifdef NMEA_CKSUM_EN
  // hex digit decode for the received checksum (uppercase only)
  always_comb begin
    hex_ok = 1'b0;
    hex_v  = char[3:0];
    if (is_dig) begin
      hex_ok = 1'b1;
    end else if ((char >= 8'h41) && (char <= 8'h46)) begin
      hex_ok = 1'b1;
      hex_v  = char[3:0] + 4'd9;
    end
  end

  assign good = !bad && (fld >= 4'd7) && (hcnt == 2'd2) && (rx_ck == xr);
`else
  assign good = !bad && (fld >= 4'd7);
`endif

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // FSM next state and per-byte actions
  always_comb begin
    state_n  = state;
    restart  = 1'b0;
    commit   = 1'b0;
    fail     = 1'b0;
    hdr_step = 1'b0;
    fld_step = 1'b0;
    cks_step = 1'b0;
    if (valid) begin
      if (char == C_DOL) begin
        restart = 1'b1;
        state_n = HDR;
      end else if ((state != IDLE) && (len >= MAXL)) begin
        fail    = 1'b1;
        state_n = IDLE;
      end else begin
        case (state)
          HDR: begin
            if (hdr_ok) begin
              hdr_step = 1'b1;
              if (hdr_cnt == 3'd4) state_n = FLD;
            end else begin
              state_n = IDLE;
            end
          end
          FLD: begin
            if (char == C_AST) begin
              if (bad) begin
                fail    = 1'b1;
                state_n = IDLE;
              end else begin
                state_n = CKS;
              end
            end else if (char == C_CR) begin
              state_n = IDLE;
`ifdef NMEA_CKSUM_EN
              fail    = 1'b1;
`else
              commit  = good;
              fail    = !good;
`endif
            end else begin
              fld_step = 1'b1;
            end
          end
          CKS: begin
            if (char == C_CR) begin
              state_n = IDLE;
              commit  = good;
              fail    = !good;
            end else begin
              cks_step = 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // datapath: shadow field accumulation, output commit and status pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len <= '0; hdr_cnt <= '0; fld <= '0; pos <= '0; in_frac <= 1'b0; fcnt <= '0; bad <= 1'b0;
      s_hr <= '0; s_min <= '0; s_sec <= '0; s_fix <= 1'b0;
      s_latd <= '0; s_latm <= '0; s_latf <= '0; s_lats <= 1'b0;
      s_lond <= '0; s_lonm <= '0; s_lonf <= '0; s_lonw <= 1'b0; s_spd <= '0;
`ifdef NMEA_CKSUM_EN
      xr <= '0; rx_ck <= '0; hcnt <= '0;
`endif
      NSR <= 1'b0; err <= 1'b0;
      hr <= '0; min <= '0; sec <= '0; fix <= 1'b0;
      lat_deg <= '0; lat_min <= '0; lat_frac <= '0; lat_s <= 1'b0;
      lon_deg <= '0; lon_min <= '0; lon_frac <= '0; lon_w <= 1'b0; spd_kn <= '0;
    end else begin
      NSR <= commit;
      err <= fail;
      if (restart) begin
        len <= 8'd1; hdr_cnt <= '0; fld <= '0; pos <= '0; in_frac <= 1'b0; fcnt <= '0; bad <= 1'b0;
        s_hr <= '0; s_min <= '0; s_sec <= '0; s_fix <= 1'b0;
        s_latd <= '0; s_latm <= '0; s_latf <= '0; s_lats <= 1'b0;
        s_lond <= '0; s_lonm <= '0; s_lonf <= '0; s_lonw <= 1'b0; s_spd <= '0;
`ifdef NMEA_CKSUM_EN
        xr <= '0; rx_ck <= '0; hcnt <= '0;
`endif
      end else begin
        if (valid && (state != IDLE)) len <= len + 8'd1;
        if (hdr_step) hdr_cnt <= hdr_cnt + 3'd1;
`ifdef NMEA_CKSUM_EN
        if (valid && ((state == HDR) || ((state == FLD) && (char != C_AST)))) xr <= xr ^ char;
        if (cks_step) begin
          if (hex_ok && (hcnt != 2'd2)) begin
            rx_ck <= {rx_ck[3:0], hex_v};
            hcnt  <= hcnt + 2'd1;
          end else begin
            bad <= 1'b1;
          end
        end
`endif
        if (fld_step) begin
          if (char == C_COM) begin
            if (fld != 4'hF) fld <= fld + 4'd1;
            pos     <= '0;
            in_frac <= 1'b0;
            fcnt    <= '0;
          end else begin
            case (fld)
              4'd0: bad <= 1'b1;
              4'd1, 4'd3, 4'd5, 4'd7: begin
                if (is_dig) begin
                  if (in_frac) begin
                    // fraction digits kept only for lat/lon, weighted so short fractions come out scaled
                    if (((fld == 4'd3) || (fld == 4'd5)) && (fcnt < FRAC_N)) begin
                      if (fld == 4'd3) s_latf <= s_latf + frac_add;
                      else             s_lonf <= s_lonf + frac_add;
                      fcnt <= fcnt + 3'd1;
                    end
                  end else begin
                    if (pos != 4'hF) pos <= pos + 4'd1;
                    case (fld)
                      4'd1: begin
                        if (pos < 4'd2)      s_hr  <= 7'(dec({1'b0, s_hr}, dig));
                        else if (pos < 4'd4) s_min <= 6'(dec({2'b0, s_min}, dig));
                        else if (pos < 4'd6) s_sec <= 6'(dec({2'b0, s_sec}, dig));
                      end
                      4'd3: begin
                        if (pos < 4'd2)      s_latd <= 7'(dec({1'b0, s_latd}, dig));
                        else if (pos < 4'd4) s_latm <= 6'(dec({2'b0, s_latm}, dig));
                      end
                      4'd5: begin
                        if (pos < 4'd3)      s_lond <= dec(s_lond, dig);
                        else if (pos < 4'd5) s_lonm <= 6'(dec({2'b0, s_lonm}, dig));
                      end
                      default: s_spd <= spd_nx;
                    endcase
                  end
                end else if ((char == C_DOT) && !in_frac) begin
                  in_frac <= 1'b1;
                end else begin
                  bad <= 1'b1;
                end
              end
              4'd2: begin
                if (char == 8'h41)      s_fix <= 1'b1;
                else if (char == 8'h56) s_fix <= 1'b0;
                else                    bad   <= 1'b1;
              end
              4'd4: begin
                if (char == 8'h53)      s_lats <= 1'b1;
                else if (char == 8'h4E) s_lats <= 1'b0;
                else                    bad    <= 1'b1;
              end
              4'd6: begin
                if (char == 8'h57)      s_lonw <= 1'b1;
                else if (char == 8'h45) s_lonw <= 1'b0;
                else                    bad    <= 1'b1;
              end
              default: ;
            endcase
          end
        end
      end
      if (commit) begin
        hr       <= hr_loc;
        min      <= s_min;
        sec      <= s_sec;
        fix      <= s_fix;
        lat_deg  <= s_latd;
        lat_min  <= s_latm;
        lat_frac <= s_latf;
        lat_s    <= s_lats;
        lon_deg  <= s_lond;
        lon_min  <= s_lonm;
        lon_frac <= s_lonf;
        lon_w    <= s_lonw;
        spd_kn   <= s_spd;
      end
    end
  end

endmodule
